// File: rtl/joy_pkg.sv
// joy_pkg: shared phase, field-index and idle constants for the Sega pad reader
package joy_pkg;
  localparam logic [7:0] PH_SEL0 = 8'd0;
  localparam logic [7:0] PH_SEL1 = 8'd1;
  localparam logic [7:0] PH_SEL2 = 8'd2;
  localparam logic [7:0] PH_SEL3 = 8'd3;
  localparam logic [7:0] PH_SEL4 = 8'd4;
  localparam logic [7:0] PH_SEL5 = 8'd5;
  localparam logic [7:0] PH_SEL6 = 8'd6;
  localparam int F_RLDU = 0;
  localparam int F_CB   = 4;
  localparam int F_SA   = 6;
  localparam int F_MXYZ = 8;
  localparam logic [11:0] JOY_IDLE = 12'hFFF;
  typedef struct packed {
    logic p9;
    logic p6;
    logic right;
    logic left;
    logic down;
    logic up;
  } pins_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-FF synchronizer with registered falling-edge detect, idle high
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic fall_o
);
  logic [2:0] s_q;
  always_ff @(posedge clk) s_q <= rst ? 3'b111 : {s_q[1:0], d_i};
  assign fall_o = s_q[2] & ~s_q[1];
endmodule

// File: rtl/joy_sega6_reader.sv
// joy_sega6_reader: scans a Sega 3/6-button or Master System pad once per 256 hsync ticks
module joy_sega6_reader
  import joy_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        hs,
  input  logic        joy_up_i,
  input  logic        joy_down_i,
  input  logic        joy_left_i,
  input  logic        joy_right_i,
  input  logic        joy_p6_i,
  input  logic        joy_p9_i,
  output logic        joy_p7_o,
  output logic [11:0] joy_s,
  output logic        six_button,
  output logic        joy_valid
);
  logic        tick;
  pins_t       s1_q, s2_q;
  logic [7:0]  ph_q, ph_d;
  logic [11:0] s_d;
  logic [3:0]  dir;
  logic        p7_d, six_d, det_q, det_d, vld_d;
  sync_edge u_hs (.clk(clk_sys), .rst(reset), .d_i(hs), .fall_o(tick));
  assign dir = {s2_q.right, s2_q.left, s2_q.down, s2_q.up};
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      s1_q       <= '1;
      s2_q       <= '1;
      ph_q       <= '0;
      joy_p7_o   <= 1'b1;
      joy_s      <= JOY_IDLE;
      six_button <= 1'b0;
      det_q      <= 1'b0;
      joy_valid  <= 1'b0;
    end else begin
      s1_q       <= {joy_p9_i, joy_p6_i, joy_right_i, joy_left_i, joy_down_i, joy_up_i};
      s2_q       <= s1_q;
      ph_q       <= ph_d;
      joy_p7_o   <= p7_d;
      joy_s      <= s_d;
      six_button <= six_d;
      det_q      <= det_d;
      joy_valid  <= vld_d;
    end
  end
  // select toggles low on even phases 0..6 and idles high for the rest of the frame
  always_comb begin
    ph_d  = tick ? ph_q + 8'd1 : ph_q;
    vld_d = tick && ph_q == PH_SEL6;
    p7_d  = tick ? 1'b1 : joy_p7_o;
    s_d   = joy_s;
    six_d = six_button;
    det_d = det_q;
    if (tick)
      case (ph_q)
        PH_SEL0, PH_SEL4: p7_d = 1'b0;
        PH_SEL1: p7_d = 1'b1;
        PH_SEL2: begin
          p7_d             = 1'b0;
          s_d[F_RLDU +: 4] = dir;
          s_d[F_CB +: 2]   = {s2_q.p9, s2_q.p6};
          det_d            = 1'b0;
        end
        PH_SEL3:
          if (!s2_q.left && !s2_q.right) s_d[F_SA +: 2] = {s2_q.p9, s2_q.p6};
          else s_d[F_CB +: 4] = {2'b11, s2_q.p9, s2_q.p6};
        PH_SEL5: det_d = det_q | (dir == 4'h0);
        PH_SEL6: begin
          p7_d             = 1'b0;
          s_d[F_MXYZ +: 4] = det_q ? dir : 4'hF;
          six_d            = det_q;
        end
        default: ;
      endcase
  end
endmodule

// File: doc/joy_sega6_reader.md
JOY_SEGA6_READER -- requirements
Module: joy_sega6_reader

Interface
REQ-001 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 hs  in  1  video horizontal sync (any polarity); only its falling edge is used as the scan tick.
REQ-004 joy_up_i, joy_down_i, joy_left_i, joy_right_i  in  1 each  DB9 pins 1-4; active-low; asynchronous.
REQ-005 joy_p6_i, joy_p9_i  in  1 each  DB9 pins 6 and 9; active-low; asynchronous.
REQ-006 joy_p7_o  out  1  DB9 pin 7 select line, driven to the pad.
REQ-007 joy_s  out  12  active-low button word, bit order MXYZ SACB RLDU (bit 11 = Mode, bit 0 = Up).
REQ-008 six_button  out  1  high when the last scan detected a 6-button pad.
REQ-009 joy_valid  out  1  one-cycle strobe when joy_s holds a completed scan.

Function
REQ-010 Each joystick input SHALL pass through a 2-FF synchronizer before use.
REQ-011 hs SHALL be synchronized with 2 FFs; tick = previous synced hs high AND current synced hs low; tick is one clk_sys cycle wide.
REQ-012 An 8-bit phase counter SHALL increment by 1 on every tick and wrap 255->0; it does not change between ticks.
REQ-013 All actions in REQ-014..REQ-020 occur only on a tick, keyed on the counter value before the increment.
REQ-014 Phase 0: p7 <= 0.
REQ-015 Phase 1: p7 <= 1.
REQ-016 Phase 2:
- joy_s[3:0] <= {right,left,down,up}.
- joy_s[5:4] <= {p9,p6}.
- p7 <= 0.
- internal six-button detect flag <= 0.
REQ-017 Phase 3, if synced left and right are both 0 (Mega Drive pad): joy_s[7:6] <= {p9,p6}.
REQ-018 Phase 3, otherwise (Master System pad): joy_s[7:4] <= {1,1,p9,p6}.
REQ-019 Phase 3 also sets p7 <= 1.
REQ-020 Phase 4: p7 <= 0.
REQ-021 Phase 5: detect flag <= 1 if up, down, left and right are all 0; p7 <= 1.
REQ-022 Phase 6: p7 <= 0 and joy_valid pulses high for the cycle after the tick.
REQ-023 Phase 6, detect flag set: joy_s[11:8] <= {right,left,down,up} and six_button <= 1.
REQ-024 Phase 6, detect flag clear: joy_s[11:8] <= 4'hF and six_button <= 0.
REQ-025 Phases 7-255: p7 <= 1; joy_s, six_button and the detect flag hold.
REQ-026 joy_p7_o SHALL be the registered p7 value, with no combinational path from any input.
REQ-027 Scan latency: 7 ticks from phase 0 to joy_valid; a full scan repeats every 256 ticks.
REQ-028 No hs edge for any duration: all outputs and state hold.

Reset
REQ-029 While reset is high, on each clk_sys edge:
- counter <= 0
- joy_p7_o <= 1
- joy_s <= 12'hFFF
- six_button <= 0
- detect flag <= 0
- joy_valid <= 0
- synchronizer and edge-detect FFs <= 1 (idle-high inputs)
REQ-030 A tick coincident with reset SHALL be ignored.
REQ-031 Reset asserted mid-scan aborts the scan with no joy_valid pulse; the next scan starts at phase 0 after release.

Structure
REQ-032 A shared package joy_pkg SHALL hold:
- phase constants PH_SEL0..PH_SEL6
- bit-index constants for the MXYZ SACB RLDU fields
- JOY_IDLE = 12'hFFF
REQ-033 A sub-module sync_edge SHALL provide the 2-FF synchronizer with a falling-edge output, instantiated for hs.
REQ-034 Two pads are handled by two instances of joy_sega6_reader; there is no shared state between instances.

Verification
REQ-035 Reset released, no hs -> joy_s = FFF, joy_p7_o = 1, six_button = 0, joy_valid never asserted.
REQ-036 3-button MD model, A+Start+Right pressed, 256 hs pulses -> joy_valid once at phase 6, joy_s = 12'hF37, six_button = 0.
REQ-037 6-button model (phase 5 drives pins 1-4 low, phase 6 drives X pressed) -> six_button = 1, joy_s[11:8] = 4'hB.
REQ-038 Master System pad, pins 6 and 9 low, left/right high at phase 3 -> joy_s[7:4] = 4'hC, joy_s[11:8] = 4'hF.
REQ-039 joy_p7_o waveform across phases 0..7 = 0,1,0,1,0,1,0,1, then 1 through phase 255; counter wraps 255->0 correctly.
REQ-040 Reset pulsed at phase 4 -> no joy_valid, all outputs at reset values; the following scan completes normally.
